// File: rtl/ld_down_cntr.sv
// Loadable down counter with a one-shot or auto-reload terminal count.
// Q, tc and busy are all registered; an asynchronous reset clears every flop.
module ld_down_cntr #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] D,
  input  logic         en,
  input  logic         reload_mode,
  output logic [N-1:0] Q,
  output logic         tc,
  output logic         busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [N-1:0] ZERO = '0;
  localparam logic [N-1:0] ONE  = N'(1);

  state_t       state;
  logic [N-1:0] rld;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      Q     <= '0;
      rld   <= '0;
      tc    <= 1'b0;
      busy  <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (load) begin
        Q   <= D;
        rld <= D;
        if (D != ZERO) begin
          state <= RUN;
          busy  <= 1'b1;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end else if (state == RUN && en) begin
        // Q==0 never occurs in RUN, so the decrement cannot wrap.
        if (Q > ONE) begin
          Q <= Q - ONE;
        end else if (Q == ONE) begin
          tc <= 1'b1;
          if (reload_mode) begin
            Q <= rld;
          end else begin
            Q     <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ld_down_cntr.sv
// Bench for ld_down_cntr: directed spec scenarios plus random stimulus,
// all checked against a behavioural model of the counter.
module tb_ld_down_cntr;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset, load, en, reload_mode;
  logic [N-1:0] D;
  logic [N-1:0] Q;
  logic         tc, busy;

  ld_down_cntr #(.N(N)) dut (
    .clk(clk), .reset(reset), .load(load), .D(D), .en(en),
    .reload_mode(reload_mode), .Q(Q), .tc(tc), .busy(busy)
  );

  always #30 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // behavioural model: remaining count, reload value, running flag, tc pulse
  int mq, mrld;
  bit mrun, mtc;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq = 0; mrld = 0; mrun = 0; mtc = 0;
  endtask

  task automatic model_edge(input bit l, input int d, input bit e, input bit rm);
    mtc = 0;
    if (l) begin
      mq = d; mrld = d; mrun = (d != 0);
    end else if (mrun && e) begin
      if (mq == 1) begin
        mtc = 1;
        if (rm) mq = mrld;
        else begin mq = 0; mrun = 0; end
      end else begin
        mq = mq - 1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_q"},    int'(Q),    mq);
    chk({tag, "_tc"},   int'(tc),   int'(mtc));
    chk({tag, "_busy"}, int'(busy), int'(mrun));
  endtask

  // called at a negedge: drive, take one rising edge, check at the next negedge
  task automatic step(input bit l, input int d, input bit e, input bit rm, input string tag);
    load = l; D = N'(d); en = e; reload_mode = rm;
    @(posedge clk);
    model_edge(l, d, e, rm);
    @(negedge clk);
    check_model(tag);
  endtask

  initial begin
    int os_q[6] = '{4, 3, 2, 1, 0, 0};
    int ar_q[10] = '{2, 1, 3, 2, 1, 3, 2, 1, 3, 2};
    bit eg_en[6] = '{1, 0, 0, 1, 1, 1};
    int eg_q[6] = '{3, 3, 3, 2, 1, 0};
    int cnt;

    reset = 1'b1; load = 0; D = '0; en = 0; reload_mode = 0;
    model_reset();
    #50 reset = 1'b0;
    @(negedge clk);
    check_model("rst");
    // IDLE ignores en
    step(0, 0, 1, 1, "idle_en");
    chk("idle_q", int'(Q), 0);

    // one-shot from 5
    step(1, 5, 1, 0, "os_ld");
    chk("os_ld_q", int'(Q), 5);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1, 0, "os");
      chk("os_q_c", int'(Q), os_q[i]);
      chk("os_tc_c", int'(tc), (i == 4) ? 1 : 0);
    end

    // auto-reload from 3
    step(1, 3, 1, 1, "ar_ld");
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 1, "ar");
      chk("ar_q_c", int'(Q), ar_q[i]);
      chk("ar_busy_c", int'(busy), 1);
    end

    // enable gating from 4
    step(1, 4, 0, 0, "eg_ld");
    for (int i = 0; i < 6; i++) begin
      step(0, 0, eg_en[i], 0, "eg");
      chk("eg_q_c", int'(Q), eg_q[i]);
    end

    // load collides with terminal cycle
    step(1, 2, 1, 0, "col_ld");
    step(0, 0, 1, 0, "col_run");
    step(1, 9, 1, 0, "col");
    chk("col_q_c", int'(Q), 9);
    chk("col_tc_c", int'(tc), 0);
    chk("col_busy_c", int'(busy), 1);
    step(1, 0, 1, 0, "ld0");
    chk("ld0_busy_c", int'(busy), 0);

    // tc latency for max value
    step(1, 15, 1, 0, "d15_ld");
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 1, 0, "d15");
      cnt++;
      if (tc) break;
    end
    chk("d15_lat", cnt, 15);

    // asynchronous abort at Q==6
    step(1, 8, 1, 0, "ab_ld");
    step(0, 0, 1, 0, "ab1");
    step(0, 0, 1, 0, "ab2");
    chk("ab_pre_q", int'(Q), 6);
    #10 reset = 1'b1;
    #5;
    model_reset();
    check_model("ab_async");
    #5 reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 1, "ab_post");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bit l = ($urandom_range(0, 7) == 0);
      int d = (N == 4 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : $urandom_range(0, 15);
      step(l, d, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ld_down_cntr.md
LD_DOWN_CNTR -- requirements
Module: ld_down_cntr

Interface
REQ-001 Parameter: N, default 4, counter width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 load  input  1  parallel-load strobe; sampled on rising clk.
REQ-005 D  input  N  load value.
REQ-006 en  input  1  count enable; decrement only when high.
REQ-007 reload_mode  input  1  1 = auto-reload at terminal count, 0 = one-shot.
REQ-008 Q  output  N  current count, registered.
REQ-009 tc  output  1  terminal-count pulse, registered, one clk wide.
REQ-010 busy  output  1  high while in RUN state, registered.

Function
REQ-011 Internal state SHALL be: two-state FSM {IDLE, RUN}, plus an N-bit reload register rld.
REQ-012 load=1, any state: Q<=D, rld<=D, tc<=0; next state RUN if D!=0, IDLE if D==0.
REQ-013 load has priority over en and over terminal-count handling in the same cycle.
REQ-014 IDLE, load=0: Q and rld hold, tc<=0, en ignored.
REQ-015 RUN, load=0, en=0: Q holds, tc<=0, state holds.
REQ-016 RUN, load=0, en=1, Q>1: Q<=Q-1, tc<=0.
REQ-017 RUN, load=0, en=1, Q==1, reload_mode=0: Q<=0, tc<=1, next state IDLE.
REQ-018 RUN, load=0, en=1, Q==1, reload_mode=1: Q<=rld, tc<=1, state stays RUN.
REQ-019 reload_mode SHALL be sampled only in the terminal cycle (REQ-017/018); changes elsewhere have no effect.
REQ-020 tc SHALL be high for exactly one clk after each terminal decrement; it is never high for two consecutive cycles, except auto-reload with rld==1 and en held high, where it is high every cycle.
REQ-021 busy SHALL equal (state==RUN) and update in the same edge as the state.
REQ-022 Q SHALL never wrap from 0 to all-ones; the decrement below 1 is unreachable by construction.
REQ-023 A period of N-cycle count from load value V with en constantly high SHALL assert tc exactly V cycles after the load edge.
REQ-024 All arithmetic SHALL be N-bit unsigned; D = 2^N-1 is legal.

Reset
REQ-025 reset=1 SHALL asynchronously force Q=0, rld=0, tc=0, busy=0, state IDLE, independent of clk.
REQ-026 Reset asserted mid-count SHALL abort the count immediately; no tc is generated on or after the abort.
REQ-027 After reset deasserts, the block SHALL stay IDLE until a load; first load is honored on the first rising edge with reset low.

Verification (N=4, clk period 60 ns)
REQ-028 Reset: reset=1 at t=0, release at 50 ns -> Q=0, tc=0, busy=0 until the first load.
REQ-029 One-shot: load D=5, reload_mode=0, en=1 -> Q 5,4,3,2,1,0; tc high one cycle with Q=0; busy falls the same edge; Q stays 0.
REQ-030 Auto-reload: load D=3, reload_mode=1, en=1 for 10 cycles -> Q 3,2,1,3,2,1,3,...; tc pulses every 3rd cycle; busy stays 1.
REQ-031 Enable gating: D=4, en toggled 1,0,0,1,1,1 -> Q 4,3,3,3,2,1,0; tc only after the 1->0 step.
REQ-032 Collisions: load D=9 in the cycle Q==1 with en=1 -> Q=9, tc=0, busy=1. Load D=0 -> Q=0, IDLE, tc=0. D=15 -> tc 15 cycles after load.
REQ-033 Async abort: reset pulse 10 ns wide mid-count at Q=6 -> Q=0 and busy=0 immediately, with no clk edge; no tc follows.
